spi_ram_burst_wrapper: RTL and testbench
========================================

// Module: spi_ram_burst_wrapper
// PURPOSE
//   Parametrised SPI slave with an integrated single-port RAM, the next generation of the SPI+RAM wrapper.
//   Decodes 2-bit opcode frames on MOSI to load the write and read address pointers, write words and read words back on MISO.
//   Adds generic data/address widths, out-of-range protection and an abort flag.
//   Optional burst streaming (SPI_BURST_EN). Sits at top level between the SPI pins and the chip's register store.
// PARAMETERS
//   DATA_WIDTH  8    RAM word width, bits per data payload
//   ADDR_WIDTH  8    address payload width
//   MEM_DEPTH   256  number of RAM words (<= 2**ADDR_WIDTH)
// PORTS
//   clk      in   1           system clock; also the SPI bit clock, rising edge
//   rst      in   1           synchronous, active-high reset
//   SS_n     in   1           slave select, active low; frame = SS_n low interval
//   MOSI     in   1           serial in, MSB first, sampled on rising clk
//   MISO     out  1           serial out, registered, MSB first
//   frm_err  out  1           1-cycle pulse: frame aborted by SS_n rise mid-payload
// BEHAVIOUR
//   Reset: MISO=0, frm_err=0, FSM=IDLE, wr_ptr=0, rd_ptr=0, bit counter=0; RAM contents not cleared.
//   Edge index k counts rising edges with SS_n low, k=0 at the first such edge. MOSI is sampled on every in-frame edge.
//   Opcode = {bit@k0, bit@k1}:
//     00 WR_ADDR: next ADDR_WIDTH bits -> wr_ptr, loaded on the edge sampling the LSB
//     01 WR_DATA: next DATA_WIDTH bits -> word; RAM[wr_ptr] written on the edge after the LSB
//     10 RD_ADDR: next ADDR_WIDTH bits -> rd_ptr, loaded on the edge sampling the LSB
//     11 RD_DATA: RAM[rd_ptr] read at k2; MISO=word MSB after k3; one bit per edge; LSB after k(2+DATA_WIDTH);
//                 MOSI ignored during the read
//   FSM: IDLE -> CMD (SS_n low) -> WADDR | WDATA | RADDR | RDATA -> DONE.
//     DONE ignores MOSI, MISO=0. Any state -> IDLE on the edge where SS_n is sampled high.
//   Abort: SS_n high before the payload LSB -> no pointer load, no RAM write, frm_err=1 for 1 cycle, MISO=0 next cycle.
//     SS_n high in IDLE or DONE: no frm_err.
//   Out of range: pointer >= MEM_DEPTH -> write dropped, read returns all-zero word; pointer value still stored.
//   Widths: pointers are ADDR_WIDTH bits; increment wraps MEM_DEPTH-1 -> 0.
//   rst has priority over every in-flight transfer; the next frame needs a fresh SS_n low after rst drops.
//   Back-to-back frames: SS_n high for 1 cycle is sufficient.
// CONFIGURATION
//   SPI_BURST_EN defined:
//     - WDATA/RDATA do not go to DONE. After each word the pointer increments (with wrap) and the next DATA_WIDTH bits
//       are the next word, until SS_n rises.
//     - Read stream has no gap: MSB of word n+1 follows LSB of word n on the next edge (prefetch required).
//     - SS_n rise on a word boundary is not an abort.
//   SPI_BURST_EN undefined: pointers never auto-increment; exactly one word per data frame, then DONE.
// TESTING
//   1 rst=1 for 2 cycles mid RD_DATA -> MISO=0 and frm_err=0 next cycle; then WR_ADDR 0x05, WR_DATA 0xA5,
//     RD_ADDR 0x05, RD_DATA -> MISO 1010_0101 on edges k3..k10.
//   2 WR_DATA 0x3C with SS_n high after 4 data bits -> frm_err 1-cycle pulse; RD_DATA at same addr returns the old word.
//   3 MEM_DEPTH=200: WR_ADDR 0xF0, WR_DATA 0xFF, RD_ADDR 0xF0, RD_DATA -> 0x00; RAM[0x70] unchanged.
//   4 SPI_BURST_EN: WR_ADDR 0xFF, WR_DATA stream 0x11,0x22 -> RAM[0xFF]=0x11, RAM[0x00]=0x22 (wrap).
//   5 SPI_BURST_EN: RD_ADDR 0x10, RD_DATA 3 words -> RAM[0x10..0x12] on MISO contiguously, 24 bits, no gap.
//   6 Non-burst: WR_DATA frame with 16 data bits -> only the first 8 written; bits 9-16 ignored; wr_ptr unchanged.

Source files
------------

// File: rtl/spi_ram_burst_wrapper_if.sv
// SPI pin bundle for the SPI+RAM wrapper: slave select, serial data both ways
// and the frame-abort flag.
interface spi_ram_burst_wrapper_if;
    logic SS_n;
    logic MOSI;
    logic MISO;
    logic frm_err;

    modport master (output SS_n, MOSI, input MISO, frm_err);
    modport slave  (input SS_n, MOSI, output MISO, frm_err);
endinterface

// File: rtl/spi_ram_burst_wrapper.sv
// spi_ram_burst_wrapper: SPI slave fronting a single-port word RAM.
// Each frame (SS_n low) carries a 2-bit opcode, then an address or data
// payload, MSB first. Out-of-range pointers drop writes and read as zero.
// Optional macro SPI_BURST_EN: data frames stream consecutive words with
// auto-incrementing (wrapping) pointers until SS_n rises.
module spi_ram_burst_wrapper #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    spi_ram_burst_wrapper_if.slave spi
);
`ifdef SPI_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif
    localparam int SW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW = $clog2(SW + 1);
    localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [CW-1:0]         A_LAST   = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0]         D_LAST   = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0]         D_FULL   = CW'(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(MEM_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE, CMD, WADDR, WDATA, RADDR, RDATA, DONE
    } state_t;

    state_t state_q, state_d;

    logic                  ss_n, mosi;
    logic [CW-1:0]         cnt_q;
    logic                  op0_q;
    logic [SW-1:0]         sh_q, sh_nxt;
    logic [DATA_WIDTH-1:0] rsh_q;
    logic                  miso_q, frm_err_q;
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, wr_ptr_inc, rd_ptr_inc, wr_addr_q;
    logic                  wr_pend_q;
    logic [DATA_WIDTH-1:0] wr_word_q;
    logic                  bnd_q;      // last edge completed a word (burst)
    logic                  wait_hi_q;  // after reset, wait for SS_n high
    logic [DATA_WIDTH-1:0] rd_word_cur, rd_word_inc;

    // FSM output strobes
    logic shift_in, ld_wr_ptr, ld_rd_ptr, wdata_last, rd_emit, rd_fetch, abort;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] p);
        return {1'b0, p} < DEPTH_W;
    endfunction

    assign ss_n        = spi.SS_n;
    assign mosi        = spi.MOSI;
    assign spi.MISO    = miso_q;
    assign spi.frm_err = frm_err_q;

    assign sh_nxt      = {sh_q[SW-2:0], mosi};
    assign wr_ptr_inc  = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
    assign rd_ptr_inc  = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
    assign rd_word_cur = in_range(rd_ptr)     ? mem[rd_ptr[IW-1:0]]     : '0;
    assign rd_word_inc = in_range(rd_ptr_inc) ? mem[rd_ptr_inc[IW-1:0]] : '0;

    // State register; reset wins over any in-flight frame
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: SS_n high always returns to IDLE
    always_comb begin
        state_d = state_q;
        if (ss_n) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (!wait_hi_q) state_d = CMD;
                CMD:     state_d = op0_q ? (mosi ? RDATA : RADDR)
                                         : (mosi ? WDATA : WADDR);
                WADDR,
                RADDR:   if (cnt_q == A_LAST) state_d = DONE;
                WDATA:   if (!BURST && cnt_q == D_LAST) state_d = DONE;
                RDATA:   if (!BURST && cnt_q == D_FULL) state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output strobes decoded from state, counter and pins
    always_comb begin
        shift_in   = 1'b0;
        ld_wr_ptr  = 1'b0;
        ld_rd_ptr  = 1'b0;
        wdata_last = 1'b0;
        rd_emit    = 1'b0;
        rd_fetch   = 1'b0;
        abort      = 1'b0;
        if (ss_n) begin
            // Aborted unless idle, finished, or sitting on a burst word boundary
            abort = (state_q inside {CMD, WADDR, WDATA, RADDR, RDATA}) && !bnd_q;
        end else begin
            shift_in   = state_q inside {WADDR, WDATA, RADDR};
            ld_wr_ptr  = (state_q == WADDR) && (cnt_q == A_LAST);
            ld_rd_ptr  = (state_q == RADDR) && (cnt_q == A_LAST);
            wdata_last = (state_q == WDATA) && (cnt_q == D_LAST);
            rd_emit    = (state_q == RDATA) && (cnt_q != '0);
            rd_fetch   = (state_q == RDATA) &&
                         ((cnt_q == '0) || (BURST && cnt_q == D_FULL));
        end
    end

    // Datapath: shift registers, pointers, MISO and abort flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            op0_q     <= 1'b0;
            sh_q      <= '0;
            rsh_q     <= '0;
            miso_q    <= 1'b0;
            frm_err_q <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wr_addr_q <= '0;
            wr_pend_q <= 1'b0;
            wr_word_q <= '0;
            bnd_q     <= 1'b0;
            wait_hi_q <= 1'b1;
        end else begin
            miso_q    <= rd_emit ? rsh_q[DATA_WIDTH-1] : 1'b0;
            frm_err_q <= abort;
            wr_pend_q <= 1'b0;
            if (ss_n) begin
                cnt_q     <= '0;
                bnd_q     <= 1'b0;
                wait_hi_q <= 1'b0;
            end else begin
                bnd_q <= 1'b0;
                if (state_q == IDLE) op0_q <= mosi;
                if (state_q == CMD)  cnt_q <= '0;
                if (shift_in) begin
                    sh_q  <= sh_nxt;
                    cnt_q <= cnt_q + 1'b1;
                end
                if (ld_wr_ptr) wr_ptr <= sh_nxt[ADDR_WIDTH-1:0];
                if (ld_rd_ptr) rd_ptr <= sh_nxt[ADDR_WIDTH-1:0];
                if (wdata_last) begin
                    // RAM write lands one edge later, even if SS_n rises then
                    wr_pend_q <= 1'b1;
                    wr_word_q <= sh_nxt[DATA_WIDTH-1:0];
                    wr_addr_q <= wr_ptr;
                    if (BURST) begin
                        wr_ptr <= wr_ptr_inc;
                        cnt_q  <= '0;
                        bnd_q  <= 1'b1;
                    end
                end
                if (rd_emit) begin
                    rsh_q <= {rsh_q[DATA_WIDTH-2:0], 1'b0};
                    cnt_q <= cnt_q + 1'b1;
                end
                if (rd_fetch) begin
                    cnt_q <= CW'(1);
                    if (cnt_q == '0) begin
                        rsh_q <= rd_word_cur;
                    end else begin
                        // Prefetch next word while the LSB goes out: no gap
                        rsh_q  <= rd_word_inc;
                        rd_ptr <= rd_ptr_inc;
                        bnd_q  <= 1'b1;
                    end
                end
            end
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && wr_pend_q && in_range(wr_addr_q))
            mem[wr_addr_q[IW-1:0]] <= wr_word_q;
    end
endmodule

// File: tb/tb_spi_ram_burst_wrapper.sv
// Testbench for spi_ram_burst_wrapper: two instances (256 and 200 words)
// share the SPI pins; a vector table of frames plus hand sequences for reset,
// abort, overrun and (with SPI_BURST_EN) streaming.
module tb_spi_ram_burst_wrapper;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ss_n = 1'b1;
    logic mosi = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    spi_ram_burst_wrapper_if if_a ();
    spi_ram_burst_wrapper_if if_b ();
    assign if_a.SS_n = ss_n;
    assign if_a.MOSI = mosi;
    assign if_b.SS_n = ss_n;
    assign if_b.MOSI = mosi;

    spi_ram_burst_wrapper #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(256)) dut_a (
        .clk(clk), .rst(rst), .spi(if_a));
    spi_ram_burst_wrapper #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(200)) dut_b (
        .clk(clk), .rst(rst), .spi(if_b));

    typedef struct {
        logic [1:0] op;     // 0 WR_ADDR, 1 WR_DATA, 2 RD_ADDR, 3 RD_DATA
        logic [7:0] val;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
    } vec_t;

    localparam int NV = 26;
    vec_t tbl [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock edge with the given pins; returns 1ns after the edge
    task automatic step(input logic s, input logic m);
        ss_n = s;
        mosi = m;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b0, v[i]);
    endtask

    task automatic wr_addr(input logic [7:0] a);
        step(1'b0, 1'b0); step(1'b0, 1'b0); send_bits(32'(a), 8); step(1'b1, 1'b0);
    endtask

    task automatic rd_addr(input logic [7:0] a);
        step(1'b0, 1'b1); step(1'b0, 1'b0); send_bits(32'(a), 8); step(1'b1, 1'b0);
    endtask

    task automatic wr_data(input logic [31:0] v, input int nbytes);
        step(1'b0, 1'b0); step(1'b0, 1'b1); send_bits(v, nbytes * 8); step(1'b1, 1'b0);
    endtask

    task automatic rd_data(input int nw, output logic [31:0] ca, output logic [31:0] cb);
        ca = '0;
        cb = '0;
        step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b0);
        for (int i = 0; i < nw * 8; i++) begin
            step(1'b0, 1'b0);
            ca = {ca[30:0], if_a.MISO};
            cb = {cb[30:0], if_b.MISO};
        end
        step(1'b1, 1'b0);
    endtask

    task automatic rd_at(input string name, input logic [7:0] a,
                         input logic [7:0] ea, input logic [7:0] eb);
        logic [31:0] ca, cb;
        rd_addr(a);
        rd_data(1, ca, cb);
        check({name, "_a"}, ca, 32'(ea));
        check({name, "_b"}, cb, 32'(eb));
    endtask

    initial begin
        logic [31:0] ca, cb;

        tbl[0]  = '{2'd0, 8'h05, 8'h00, 8'h00};
        tbl[1]  = '{2'd1, 8'hA5, 8'h00, 8'h00};
        tbl[2]  = '{2'd2, 8'h05, 8'h00, 8'h00};
        tbl[3]  = '{2'd3, 8'h00, 8'hA5, 8'hA5};
        tbl[4]  = '{2'd0, 8'h70, 8'h00, 8'h00};
        tbl[5]  = '{2'd1, 8'h5A, 8'h00, 8'h00};
        tbl[6]  = '{2'd2, 8'h70, 8'h00, 8'h00};
        tbl[7]  = '{2'd3, 8'h00, 8'h5A, 8'h5A};
        tbl[8]  = '{2'd0, 8'hF0, 8'h00, 8'h00};
        tbl[9]  = '{2'd1, 8'hFF, 8'h00, 8'h00};
        tbl[10] = '{2'd2, 8'hF0, 8'h00, 8'h00};
        tbl[11] = '{2'd3, 8'h00, 8'hFF, 8'h00};
        tbl[12] = '{2'd2, 8'h70, 8'h00, 8'h00};
        tbl[13] = '{2'd3, 8'h00, 8'h5A, 8'h5A};
        tbl[14] = '{2'd0, 8'hC7, 8'h00, 8'h00};
        tbl[15] = '{2'd1, 8'h3C, 8'h00, 8'h00};
        tbl[16] = '{2'd2, 8'hC7, 8'h00, 8'h00};
        tbl[17] = '{2'd3, 8'h00, 8'h3C, 8'h3C};
        tbl[18] = '{2'd0, 8'hC8, 8'h00, 8'h00};
        tbl[19] = '{2'd1, 8'h81, 8'h00, 8'h00};
        tbl[20] = '{2'd2, 8'hC8, 8'h00, 8'h00};
        tbl[21] = '{2'd3, 8'h00, 8'h81, 8'h00};
        tbl[22] = '{2'd0, 8'h00, 8'h00, 8'h00};
        tbl[23] = '{2'd1, 8'h96, 8'h00, 8'h00};
        tbl[24] = '{2'd2, 8'h00, 8'h00, 8'h00};
        tbl[25] = '{2'd3, 8'h00, 8'h96, 8'h96};

        // Reset state
        rst = 1'b1;
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
        rst = 1'b0;
        check("reset_miso_a", 32'(if_a.MISO), 32'd0);
        check("reset_ferr_a", 32'(if_a.frm_err), 32'd0);
        check("reset_miso_b", 32'(if_b.MISO), 32'd0);
        check("reset_ferr_b", 32'(if_b.frm_err), 32'd0);
        step(1'b1, 1'b0);

        // Vector table: address/data frames, reads compared against both RAMs
        for (int v = 0; v < NV; v++) begin
            case (tbl[v].op)
                2'd0: wr_addr(tbl[v].val);
                2'd1: wr_data(32'(tbl[v].val), 1);
                2'd2: rd_addr(tbl[v].val);
                default: begin
                    rd_data(1, ca, cb);
                    check($sformatf("vec%0d_rd_a", v), ca, 32'(tbl[v].exp_a));
                    check($sformatf("vec%0d_rd_b", v), cb, 32'(tbl[v].exp_b));
                    check($sformatf("vec%0d_ferr", v), 32'(if_a.frm_err), 32'd0);
                end
            endcase
        end

        // Reset in the middle of a read, SS_n held low through and after it
        rd_addr(8'h05);
        step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b0);
        check("midread_msb", 32'(if_a.MISO), 32'd1);
        rst = 1'b1;
        step(1'b0, 1'b0);
        check("rst1_miso", 32'(if_a.MISO), 32'd0);
        check("rst1_ferr", 32'(if_a.frm_err), 32'd0);
        step(1'b0, 1'b0);
        check("rst2_miso", 32'(if_a.MISO), 32'd0);
        rst = 1'b0;
        step(1'b0, 1'b0); step(1'b0, 1'b0);
        check("postrst_miso", 32'(if_a.MISO), 32'd0);
        step(1'b1, 1'b0);
        check("postrst_no_ferr", 32'(if_a.frm_err), 32'd0);
        // rd_ptr back to 0 after reset
        rd_data(1, ca, cb);
        check("postrst_rd0_a", ca, 32'h96);
        check("postrst_rd0_b", cb, 32'h96);
        rd_at("postrst_rd05", 8'h05, 8'hA5, 8'hA5);

        // Write aborted after 4 data bits of 0x3C
        wr_addr(8'h05);
        step(1'b0, 1'b0); step(1'b0, 1'b1);
        send_bits(32'h3, 4);
        step(1'b1, 1'b0);
        check("wabort_ferr_a", 32'(if_a.frm_err), 32'd1);
        check("wabort_ferr_b", 32'(if_b.frm_err), 32'd1);
        step(1'b1, 1'b0);
        check("wabort_pulse_end", 32'(if_a.frm_err), 32'd0);
        rd_at("wabort_old", 8'h05, 8'hA5, 8'hA5);

        // Read aborted after two bits
        step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b0);
        step(1'b0, 1'b0); step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("rabort_ferr", 32'(if_a.frm_err), 32'd1);
        check("rabort_miso", 32'(if_a.MISO), 32'd0);
        step(1'b1, 1'b0);

`ifndef SPI_BURST_EN
        // Overlong single-word write: extra bits ignored, pointer stays
        wr_addr(8'h21);
        wr_data(32'h11, 1);
        wr_addr(8'h20);
        wr_data(32'h5AC3, 2);
        check("overrun_no_ferr", 32'(if_a.frm_err), 32'd0);
        rd_at("overrun_20", 8'h20, 8'h5A, 8'h5A);
        rd_at("overrun_21", 8'h21, 8'h11, 8'h11);
        wr_data(32'h77, 1);
        rd_at("noinc_20", 8'h20, 8'h77, 8'h77);
        rd_at("noinc_21", 8'h21, 8'h11, 8'h11);
`else
        // Burst write wrapping 0xFF -> 0x00
        wr_addr(8'hFF);
        wr_data(32'h1122, 2);
        check("bwr_no_ferr", 32'(if_a.frm_err), 32'd0);
        rd_at("bwr_ff", 8'hFF, 8'h11, 8'h00);
        rd_at("bwr_00", 8'h00, 8'h22, 8'h22);
        // Gapless 3-word read stream
        wr_addr(8'h10);
        wr_data(32'hDEADBE, 3);
        rd_addr(8'h10);
        rd_data(3, ca, cb);
        check("brd_stream_a", ca, 32'hDEADBE);
        check("brd_stream_b", cb, 32'hDEADBE);
        check("brd_no_ferr", 32'(if_a.frm_err), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
